// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus for mem_access_unit.
// The master drives a dword-aligned request and holds it until the slave acknowledges.
interface mem_access_unit_if #(
  parameter int DATA_W = 64
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [7:0]        dmem_be;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: lane alignment, byte enables, load extension, stall control.
// Optional MEM_ACCESS_ALIGN_CHECK_EN flags misaligned accesses instead of force-aligning them.
module mem_access_unit #(
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [1:0]        size_in,
  input  logic              sign_ext_in,
  input  logic [DATA_W-1:0] addr_in,
  input  logic [DATA_W-1:0] store_data_in,
  output logic              stall_out,
  output logic [DATA_W-1:0] load_data_out,
  output logic              load_valid_out,
  output logic              misalign_out,
  mem_access_unit_if.master dmem
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic              rst_done;
  logic              we_r;
  logic [1:0]        size_r;
  logic              sign_r;
  logic [2:0]        off_r;
  logic [DATA_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [7:0]        be_r;

  logic              start;
  logic              mis;
  logic [2:0]        align_mask;
  logic [DATA_W-1:0] addr_eff;
  logic [7:0]        be_base;
  logic [DATA_W-1:0] rd_sh;
  logic [DATA_W-1:0] fmt;

  // rst_done blocks a start on the first edge after reset release
  assign start = rst_done && valid_in && (mem_read_in || mem_write_in) &&
                 ((state == IDLE) || (state == DONE));
  assign stall_out = start || (state == REQ);

  always_comb begin
    align_mask = 3'b000;
    be_base    = 8'h01;
    unique case (size_in)
      2'd0: begin align_mask = 3'b000; be_base = 8'h01; end
      2'd1: begin align_mask = 3'b001; be_base = 8'h03; end
      2'd2: begin align_mask = 3'b011; be_base = 8'h0F; end
      2'd3: begin align_mask = 3'b111; be_base = 8'hFF; end
    endcase
  end

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign mis      = |(addr_in[2:0] & align_mask);
  assign addr_eff = addr_in;
`else
  assign mis      = 1'b0;
  assign addr_eff = {addr_in[DATA_W-1:3], addr_in[2:0] & ~align_mask};
`endif

  always_comb begin
    rd_sh = dmem.dmem_rdata >> {off_r, 3'b000};
    fmt   = rd_sh;
    unique case (size_r)
      2'd0: fmt = {{(DATA_W-8){sign_r & rd_sh[7]}},   rd_sh[7:0]};
      2'd1: fmt = {{(DATA_W-16){sign_r & rd_sh[15]}}, rd_sh[15:0]};
      2'd2: fmt = {{(DATA_W-32){sign_r & rd_sh[31]}}, rd_sh[31:0]};
      2'd3: fmt = rd_sh;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      rst_done       <= 1'b0;
      we_r           <= 1'b0;
      size_r         <= '0;
      sign_r         <= 1'b0;
      off_r          <= '0;
      addr_r         <= '0;
      wdata_r        <= '0;
      be_r           <= '0;
      load_data_out  <= '0;
      load_valid_out <= 1'b0;
      misalign_out   <= 1'b0;
    end else begin
      rst_done       <= 1'b1;
      load_valid_out <= 1'b0;
      misalign_out   <= 1'b0;
      unique case (state)
        REQ: begin
          if (dmem.dmem_ack) begin
            state <= DONE;
            if (!we_r) begin
              load_data_out  <= fmt;
              load_valid_out <= 1'b1;
            end
          end
        end
        default: begin
          if (start) begin
            // Both read and write high is treated as a read
            we_r    <= mem_write_in && !mem_read_in;
            size_r  <= size_in;
            sign_r  <= sign_ext_in;
            off_r   <= addr_eff[2:0];
            addr_r  <= {addr_eff[DATA_W-1:3], 3'b000};
            wdata_r <= store_data_in << {addr_eff[2:0], 3'b000};
            be_r    <= be_base << addr_eff[2:0];
            if (mis) begin
              state        <= DONE;
              misalign_out <= 1'b1;
            end else begin
              state <= REQ;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign dmem.dmem_req   = (state == REQ);
  assign dmem.dmem_we    = we_r;
  assign dmem.dmem_addr  = addr_r;
  assign dmem.dmem_wdata = wdata_r;
  assign dmem.dmem_be    = be_r;

endmodule
